// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic ps2_odd_ok(input logic [7:0] data, input logic par);
    return ^{par, data};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the raw PS/2 lines plus a falling-edge detector on the clock.
`timescale 1ns/1ps
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2Clk,
  input  logic ps2Data,
  output logic dataSync,
  output logic fallEdge
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;

  // Lines idle high, so reset to 1 to avoid a spurious edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2Clk};
      data_sync_q <= {data_sync_q[0], ps2Data};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign dataSync = data_sync_q[1];
  assign fallEdge = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver with E0/F0 prefix decoding.
// Optional mid-frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
`timescale 1ns/1ps
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] keyCode,
  output logic       keyValid,
  output logic       keyBreak,
  output logic       keyExt,
  output logic       frameErr
);

  // state     | meaning
  // ST_IDLE   | waiting for a start bit (sampled 0)
  // ST_DATA   | shifting 8 data bits LSB-first
  // ST_PARITY | checking odd parity
  // ST_STOP   | checking stop bit, then deliver byte or flag error

  ps2_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_ok_q, par_ok_d;
  logic       brk_q, brk_d, ext_q, ext_d;
  logic [7:0] code_q, code_d;
  logic       valid_q, valid_d, obrk_q, obrk_d, oext_q, oext_d, err_q, err_d;
  logic       data_s, fall, timeout;

  ps2_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .ps2Clk   (ps2Clk),
    .ps2Data  (ps2Data),
    .dataSync (data_s),
    .fallEdge (fall)
  );

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned          WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]      WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wdog_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            wdog_q <= '0;
    else if (fall || state_q == ST_IDLE) wdog_q <= '0;
    else                                 wdog_q <= wdog_q + 1'b1;
  end

  assign timeout = (state_q != ST_IDLE) && !fall && (wdog_q == WD_LAST);
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      par_ok_q <= 1'b0;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      obrk_q   <= 1'b0;
      oext_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      par_ok_q <= par_ok_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      obrk_q   <= obrk_d;
      oext_q   <= oext_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_ok_d = par_ok_q;
    if (timeout) begin
      state_d = ST_IDLE;
    end else if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          shift_d = {data_s, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_d = ps2_odd_ok(shift_q, data_s);
          state_d  = ST_STOP;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Prefix bytes only arm flags; any other good byte is delivered and consumes them.
  always_comb begin
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    obrk_d  = obrk_q;
    oext_d  = oext_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    if (timeout) begin
      err_d = 1'b1;
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (fall && state_q == ST_STOP) begin
      if (data_s && par_ok_q) begin
        if (shift_q == PS2_BREAK) begin
          brk_d = 1'b1;
        end else if (shift_q == PS2_EXT) begin
          ext_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          code_d  = shift_q;
          obrk_d  = brk_q;
          oext_d  = ext_q;
          brk_d   = 1'b0;
          ext_d   = 1'b0;
        end
      end else begin
        err_d = 1'b1;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  assign keyCode  = code_q;
  assign keyValid = valid_q;
  assign keyBreak = obrk_q;
  assign keyExt   = oext_q;
  assign frameErr = err_q;

endmodule
